// File: rtl/mem_check_pkg.sv
// Shared types for the data-memory write checker: state codes, table entry layout
// and index-width helpers.
package mem_check_pkg;

    // Widest address/data the expectation table can hold (AW, DW <= MWC_MAX_W).
    localparam int MWC_MAX_W = 32;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_RUN     = 3'd1;
    localparam logic [2:0] S_PASS    = 3'd2;
    localparam logic [2:0] S_FAIL    = 3'd3;
    localparam logic [2:0] S_TIMEOUT = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE    = S_IDLE,
        ST_RUN     = S_RUN,
        ST_PASS    = S_PASS,
        ST_FAIL    = S_FAIL,
        ST_TIMEOUT = S_TIMEOUT
    } mwc_state_t;

    typedef struct packed {
        logic [MWC_MAX_W-1:0] addr;
        logic [MWC_MAX_W-1:0] data;
        logic                 is_byte;
    } mwc_entry_t;

    function automatic int mwc_idx_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/mwc_expect_table.sv
// Expected-write table: DEPTH entries, one synchronous write port, combinational read.
module mwc_expect_table
    import mem_check_pkg::*;
#(
    parameter  int DEPTH = 8,
    localparam int IW    = mwc_idx_w(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [IW-1:0] widx,
    input  mwc_entry_t    wentry,
    input  logic [IW-1:0] ridx,
    output mwc_entry_t    rentry
);

    // Contents survive reset so a table can be loaded once and re-run.
    mwc_entry_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[widx] <= wentry;
        end
    end

    assign rentry = mem[ridx];

endmodule

// File: rtl/mem_write_checker.sv
// Monitors the core's data-memory write bus against a table of expected stores and
// reports pass / fail / timeout with diagnostics.
module mem_write_checker
    import mem_check_pkg::*;
#(
    parameter  int AW      = 32,
    parameter  int DW      = 32,
    parameter  int DEPTH   = 8,
    parameter  int TIMEOUT = 4096,
    parameter  int STRICT  = 0,
    localparam int IW      = mwc_idx_w(DEPTH),
    localparam int NW      = IW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          exp_we,
    input  logic [IW-1:0] exp_idx,
    input  logic [AW-1:0] exp_addr,
    input  logic [DW-1:0] exp_data,
    input  logic          exp_byte,
    input  logic [NW-1:0] num_entries,
    input  logic          start,
    input  logic          clear,
    input  logic          mem_write,
    input  logic          mem_byte,
    input  logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] mem_wdata,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic          fail,
    output logic          timeout,
    output logic [NW-1:0] match_count,
    output logic [31:0]   cycle_count,
    output logic [AW-1:0] fail_addr,
    output logic [DW-1:0] fail_data,
    output mwc_state_t    dbg_state
);

    mwc_state_t    state_q;
    logic [IW-1:0] idx_q;
    logic [NW-1:0] num_q;
    mwc_entry_t    wr_entry;
    mwc_entry_t    cur;
    logic          addr_hit;
    logic          data_hit;
    logic          hit;
    logic          last;
    logic          start_ok;
    logic          tmo_hit;

    always_comb begin
        wr_entry               = '0;
        wr_entry.addr[AW-1:0]  = exp_addr;
        wr_entry.data[DW-1:0]  = exp_data;
        wr_entry.is_byte       = exp_byte;
    end

    mwc_expect_table #(.DEPTH(DEPTH)) u_table (
        .clk    (clk),
        .we     (exp_we && (state_q == ST_IDLE)),
        .widx   (exp_idx),
        .wentry (wr_entry),
        .ridx   (idx_q),
        .rentry (cur)
    );

    // A byte entry only constrains the low data byte; the store width must agree.
    assign addr_hit = (cur.addr[AW-1:0] == mem_addr);
    assign data_hit = cur.is_byte ? (mem_byte && (mem_wdata[7:0] == cur.data[7:0]))
                                  : (!mem_byte && (mem_wdata == cur.data[DW-1:0]));
    assign hit      = mem_write && addr_hit && data_hit;
    assign last     = ({1'b0, idx_q} == (num_q - NW'(1)));
    assign start_ok = start && (num_entries != '0) && (num_entries <= NW'(DEPTH));
    assign tmo_hit  = (cycle_count == 32'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            num_q       <= '0;
            match_count <= '0;
            cycle_count <= '0;
            fail_addr   <= '0;
            fail_data   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_ok) begin
                        state_q     <= ST_RUN;
                        idx_q       <= '0;
                        num_q       <= num_entries;
                        match_count <= '0;
                        cycle_count <= '0;
                        fail_addr   <= '0;
                        fail_data   <= '0;
                    end
                end
                ST_RUN: begin
                    if (hit) begin
                        idx_q       <= idx_q + IW'(1);
                        match_count <= match_count + NW'(1);
                    end
                    // Completion wins over a timeout landing in the same cycle.
                    if (hit && last) begin
                        state_q <= ST_PASS;
                    end else if (mem_write && !hit && (STRICT != 0)) begin
                        state_q   <= ST_FAIL;
                        fail_addr <= mem_addr;
                        fail_data <= mem_wdata;
                    end else if (tmo_hit) begin
                        state_q <= ST_TIMEOUT;
                    end else if (cycle_count != '1) begin
                        cycle_count <= cycle_count + 32'd1;
                    end
                end
                default: begin
                    if (clear) begin
                        state_q <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign busy      = (state_q == ST_RUN);
    assign pass      = (state_q == ST_PASS);
    assign fail      = (state_q == ST_FAIL);
    assign timeout   = (state_q == ST_TIMEOUT);
    assign done      = pass | fail | timeout;
    assign dbg_state = state_q;

endmodule
